// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Request/result bundle for the nibble-serial add/subtract sequencer.
// The requester drives the operands and start; the sequencer returns status and result.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  logic                   start;
  logic                   mode;
  logic [4*NIBBLES-1:0]   op_a;
  logic [4*NIBBLES-1:0]   op_b;
  logic                   busy;
  logic                   done;
  logic [4*NIBBLES-1:0]   result;
  logic                   cout;
  logic                   overflow;

  modport master (
    output start, mode, op_a, op_b,
    input  busy, done, result, cout, overflow
  );

  modport slave (
    input  start, mode, op_a, op_b,
    output busy, done, result, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Multi-word add/subtract sequencer: feeds an external combinational 4-bit slice
// one nibble per clock and chains carry/borrow into a W-bit result.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  nibble_serial_addsub_ctrl_if.slave  bus,
  output logic [3:0]                  slice_a,
  output logic [3:0]                  slice_b,
  output logic                        slice_mode,
  input  logic [3:0]                  slice_sum,
  input  logic                        slice_cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            mode_q;
  logic [3:0]      nxt_a;
  logic [3:0]      nxt_b;

  // Operand nibbles for index idx+1; zero when past the top nibble.
  always_comb begin
    nxt_a = '0;
    nxt_b = '0;
    for (int unsigned k = 0; k < NIBBLES; k++) begin
      if (k == 32'(idx) + 32'd1) begin
        nxt_a = a_q[4*k +: 4];
        nxt_b = b_q[4*k +: 4];
      end
    end
  end

  // slice_mode doubles as the chained carry register c. The slice re-inverts
  // b by its own mode pin, so b is pre-conditioned by (mode ^ c) to leave the
  // effective operand inverted exactly when subtracting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= 1'b0;
      slice_a      <= '0;
      slice_b      <= '0;
      slice_mode   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
      bus.cout     <= 1'b0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q        <= bus.op_a;
            b_q        <= bus.op_b;
            mode_q     <= bus.mode;
            idx        <= '0;
            slice_a    <= bus.op_a[3:0];
            slice_b    <= bus.op_b[3:0];
            slice_mode <= bus.mode;
            bus.busy   <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          bus.result[4*idx +: 4] <= slice_sum;
          if (idx == LAST) begin
            bus.cout     <= slice_cout;
            bus.overflow <= (a_q[W-1] == (b_q[W-1] ^ mode_q)) &&
                            (slice_sum[3] != a_q[W-1]);
            slice_a      <= '0;
            slice_b      <= '0;
            slice_mode   <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            state        <= DONE;
          end else begin
            idx        <= idx + IW'(1);
            slice_a    <= nxt_a;
            slice_b    <= nxt_b ^ {4{mode_q ^ slice_cout}};
            slice_mode <= slice_cout;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/nibble_serial_addsub_ctrl.md
# nibble_serial_addsub_ctrl

Multi-word add/subtract sequencer that drives the team's combinational 4-bit adder/subtractor slice one nibble per clock. It chains the carry or borrow across cycles to produce a NIBBLES×4-bit result with final carry and signed overflow. The block sits directly upstream and downstream of the slice: it feeds the slice's `a`/`b`/`mode` inputs and consumes its `sum`/`cout`.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; data width W = 4×NIBBLES; legal values ≥1.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: operation request; sampled only in IDLE.
- `mode` in 1: 0 = add (A+B), 1 = subtract (A−B); latched with `start`.
- `op_a` in W: operand A; latched with `start`.
- `op_b` in W: operand B; latched with `start`.
- `slice_a` out 4: nibble of A to the slice.
- `slice_b` out 4: conditioned nibble of B to the slice.
- `slice_mode` out 1: slice mode input; also acts as the carry-in.
- `slice_sum` in 4: slice sum output.
- `slice_cout` in 1: slice carry output.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse when the result is final.
- `result` out W: A±B modulo 2^W.
- `cout` out 1: final carry out. In subtract mode, 1 means no borrow (A ≥ B unsigned).
- `overflow` out 1: two's-complement overflow of the W-bit operation.

## Operation
- **FSM states:** IDLE, RUN, DONE.
  - IDLE→RUN when `start` = 1. On that edge, latch `op_a`, `op_b`, `mode`; set nibble index i = 0 and carry register c = `mode`.
  - RUN→RUN while i < NIBBLES−1; RUN→DONE after nibble NIBBLES−1 is captured.
  - DONE→IDLE unconditionally.
- **Carry trick.** The slice computes a + (b ^ {4{m}}) + m. The block drives it as follows:
  - `slice_a` = A[4i+3:4i]
  - `slice_mode` = c
  - `slice_b` = B[4i+3:4i] ^ {4{mode ^ c}}
  - The slice then returns A_i + (B_i ^ {4{mode}}) + c for all four mode/c combinations.
- **Each RUN edge:**
  - result[4i+3:4i] ← `slice_sum`
  - c ← `slice_cout`
  - i ← i+1
- **Last nibble (i = NIBBLES−1):**
  - `cout` ← `slice_cout`.
  - `overflow` ← (a3 == e3) && (s3 != a3), where a3 = A[W−1], e3 = B[W−1]^mode, s3 = `slice_sum`[3].
  - Note: e3 uses the effective operand, not `slice_b`.
- **Slice outputs outside RUN:** in IDLE and DONE, `slice_a` = 0, `slice_b` = 0, `slice_mode` = 0.
- **`start` outside IDLE:** ignored in RUN and DONE; it is not queued. Operand inputs may change freely after the latch edge.
- **Output hold:** `result`, `cout`, `overflow` hold their values after DONE until the next accepted `start`.
- **Partial results:** `result` nibbles update progressively during RUN. `result` is valid only when `done` = 1 or after it.
- **Index counter:** width max(1, $clog2(NIBBLES)). With NIBBLES = 1, RUN lasts exactly one cycle.

## Timing
- **Reset:** all outputs 0 (`busy`, `done`, `result`, `cout`, `overflow`, `slice_*`). FSM = IDLE, i = 0, c = 0.
- **Reset mid-operation:** aborts immediately (asynchronous). The next operation requires a new `start`.
- **Latency:**
  - `start` is sampled high at edge 0.
  - `busy` = 1 from edge 0 to edge NIBBLES.
  - `done` = 1 for the single cycle following edge NIBBLES.
  - Start-to-done is NIBBLES+1 cycles.
- **Throughput:** the next `start` is accepted at the earliest on the edge after `done`, i.e. one operation per NIBBLES+2 cycles.
- **Slice path:** the slice is combinational. `slice_*` outputs are from registers and `slice_sum`/`slice_cout` are captured the same cycle. There is no multicycle path.

## Test plan
The bench instantiates the real 4-bit adder/subtractor slice; NIBBLES = 4 unless noted.
- Add 0x1234 + 0x0FFF → `result` = 0x2233, `cout` = 0, `overflow` = 0, `done` exactly 5 cycles after the `start` edge.
- Subtract 0x0005 − 0x0007 → `result` = 0xFFFE, `cout` = 0 (borrow), `overflow` = 0. Subtract 0x8000 − 0x0001 → 0x7FFF, `cout` = 1, `overflow` = 1.
- Add 0x7FFF + 0x0001 → 0x8000, `cout` = 0, `overflow` = 1. Add 0xFFFF + 0x0001 → 0x0000, `cout` = 1, `overflow` = 0.
- Hold `start` = 1 continuously with new operands each cycle → only operands at IDLE edges are accepted. `busy` and `done` pattern repeats every 6 cycles, and the results match the latched operands.
- Assert `rst_n` low during nibble 2 of 0x1234 + 0x0FFF → all outputs 0 immediately, no `done`. After release, a new `start` computes correctly.
- NIBBLES = 1: subtract 0x3 − 0x5 → `result` = 0xE, `cout` = 0, `overflow` = 0, `done` 2 cycles after `start`. Random compare against a reference model, 1000 vectors per mode.
